acc_frame_ctrl: RTL and testbench

Framing generator that drives a scalar accumulator in the single-bin DFT correlator. It sits between the DFT bin output stream and the accumulator. It forwards samples with one cycle of latency and asserts `acc_done` on the first valid word of every new accumulation, with a runtime-programmable accumulation length. It also flags the first frame after enable, whose accumulator result is invalid, and counts completed accumulations.

---
 rtl/acc_frame_ctrl_if.sv | 27 ++
 rtl/acc_frame_ctrl.sv | 134 +++++++++++++
 tb/tb_acc_frame_ctrl.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/acc_frame_ctrl_if.sv
// Sample-stream and control bundle between the DFT bin output, the framer and the accumulator.
// The master side drives samples and run control; the slave (framer) drives the framed stream and the count.
interface acc_frame_ctrl_if #(
  parameter int DIN_WIDTH = 16,
  parameter int LEN_WIDTH = 16,
  parameter int CNT_WIDTH = 32
);
  logic [DIN_WIDTH-1:0] din;
  logic                 din_valid;
  logic                 enable;
  logic [LEN_WIDTH-1:0] acc_len;
  logic [DIN_WIDTH-1:0] dout;
  logic                 dout_valid;
  logic                 acc_done;
  logic                 first_acc;
  logic [CNT_WIDTH-1:0] acc_count;

  modport master (
    output din, din_valid, enable, acc_len,
    input  dout, dout_valid, acc_done, first_acc, acc_count
  );

  modport slave (
    input  din, din_valid, enable, acc_len,
    output dout, dout_valid, acc_done, first_acc, acc_count
  );
endinterface

// File: rtl/acc_frame_ctrl.sv
// Accumulator framer: forwards samples with 1 cycle latency, marks the first word of each frame.
// No back-pressure: one sample per clock; disabling drops the sample in flight and abandons the frame.
module acc_frame_ctrl #(
  parameter int DIN_WIDTH = 16,
  parameter int LEN_WIDTH = 16,
  parameter int CNT_WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  acc_frame_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [LEN_WIDTH:0]   sample_cnt;
  logic [LEN_WIDTH:0]   sample_cnt_nxt;
  logic [LEN_WIDTH-1:0] len_r;
  logic [LEN_WIDTH-1:0] len_nxt;
  logic [LEN_WIDTH-1:0] len_eff;

  logic [DIN_WIDTH-1:0] dout_r;
  logic                 dout_valid_r;
  logic                 acc_done_r;
  logic                 first_acc_r;
  logic                 vld_nxt;
  logic                 done_nxt;
  logic                 first_nxt;

  logic [CNT_WIDTH-1:0] acc_count_r;
  logic [CNT_WIDTH-1:0] acc_count_nxt;
  logic                 count_clr;

  // A zero length would never close a frame, so it behaves as a length of one.
  assign len_eff = (bus.acc_len == '0) ? LEN_WIDTH'(1) : bus.acc_len;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    sample_cnt_nxt = sample_cnt;
    len_nxt        = len_r;
    vld_nxt        = 1'b0;
    done_nxt       = 1'b0;
    first_nxt      = 1'b0;
    count_clr      = 1'b0;

    if (!bus.enable) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          state_nxt = START;
          count_clr = 1'b1;
        end
        START: begin
          if (bus.din_valid) begin
            vld_nxt        = 1'b1;
            done_nxt       = 1'b1;
            first_nxt      = 1'b1;
            len_nxt        = len_eff;
            sample_cnt_nxt = (LEN_WIDTH+1)'(1);
            state_nxt      = RUN;
          end
        end
        RUN: begin
          if (bus.din_valid) begin
            vld_nxt = 1'b1;
            if (sample_cnt == {1'b0, len_r}) begin
              done_nxt       = 1'b1;
              len_nxt        = len_eff;
              sample_cnt_nxt = (LEN_WIDTH+1)'(1);
            end else begin
              sample_cnt_nxt = sample_cnt + (LEN_WIDTH+1)'(1);
            end
          end
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  // The completed-frame count advances while the non-first boundary word is on the output,
  // so the new value is visible one cycle after that acc_done.
  always_comb begin
    acc_count_nxt = acc_count_r;
    if (count_clr) begin
      acc_count_nxt = '0;
    end else if (acc_done_r && !first_acc_r) begin
      acc_count_nxt = acc_count_r + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_cnt   <= '0;
      len_r        <= LEN_WIDTH'(1);
      dout_r       <= '0;
      dout_valid_r <= 1'b0;
      acc_done_r   <= 1'b0;
      first_acc_r  <= 1'b0;
      acc_count_r  <= '0;
    end else begin
      sample_cnt   <= sample_cnt_nxt;
      len_r        <= len_nxt;
      dout_r       <= bus.din;
      dout_valid_r <= vld_nxt;
      acc_done_r   <= done_nxt;
      first_acc_r  <= first_nxt;
      acc_count_r  <= acc_count_nxt;
    end
  end

  assign bus.dout       = dout_r;
  assign bus.dout_valid = dout_valid_r;
  assign bus.acc_done   = acc_done_r;
  assign bus.first_acc  = first_acc_r;
  assign bus.acc_count  = acc_count_r;

endmodule

// File: tb/tb_acc_frame_ctrl.sv
// Bench for acc_frame_ctrl: directed scenarios plus random traffic against a frame-level model.
module tb_acc_frame_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;

  acc_frame_ctrl_if #(.DIN_WIDTH(16), .LEN_WIDTH(16), .CNT_WIDTH(32)) bus ();

  acc_frame_ctrl #(.DIN_WIDTH(16), .LEN_WIDTH(16), .CNT_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Frame-level model: a run is either off, armed (waiting for its first word) or mid-frame
  // with some number of words still owed to the current accumulation.
  bit          m_on;
  bit          m_started;
  int          m_left;
  bit          pend_inc;
  logic [15:0] exp_dout;
  logic        exp_vld;
  logic        exp_done;
  logic        exp_first;
  logic [31:0] exp_count;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic compare_all(input string tag);
    check_eq({tag, ".dout"},       64'(bus.dout),       64'(exp_dout));
    check_eq({tag, ".dout_valid"}, 64'(bus.dout_valid), 64'(exp_vld));
    check_eq({tag, ".acc_done"},   64'(bus.acc_done),   64'(exp_done));
    check_eq({tag, ".first_acc"},  64'(bus.first_acc),  64'(exp_first));
    check_eq({tag, ".acc_count"},  64'(bus.acc_count),  64'(exp_count));
  endtask

  task automatic model_reset();
    m_on      = 1'b0;
    m_started = 1'b0;
    m_left    = 0;
    pend_inc  = 1'b0;
    exp_dout  = '0;
    exp_vld   = 1'b0;
    exp_done  = 1'b0;
    exp_first = 1'b0;
    exp_count = '0;
  endtask

  task automatic model_cycle(input bit en, input bit v, input logic [15:0] d, input logic [15:0] len);
    bit inc_now;
    bit clear;
    inc_now   = pend_inc;
    clear     = 1'b0;
    exp_dout  = d;
    exp_vld   = 1'b0;
    exp_done  = 1'b0;
    exp_first = 1'b0;
    if (!en) begin
      m_on = 1'b0;
    end else if (!m_on) begin
      m_on      = 1'b1;
      m_started = 1'b0;
      clear     = 1'b1;
    end else if (v) begin
      exp_vld = 1'b1;
      if (!m_started || m_left == 0) begin
        exp_done  = 1'b1;
        exp_first = !m_started;
        m_started = 1'b1;
        m_left    = ((len == 0) ? 1 : int'(len)) - 1;
      end else begin
        m_left = m_left - 1;
      end
    end
    if (clear)        exp_count = '0;
    else if (inc_now) exp_count = exp_count + 32'd1;
    pend_inc = exp_done && !exp_first;
  endtask

  task automatic step(input bit en, input bit v, input logic [15:0] d, input logic [15:0] len);
    @(negedge clk);
    compare_all("step");
    bus.enable    = en;
    bus.din_valid = v;
    bus.din       = d;
    bus.acc_len   = len;
    model_cycle(en, v, d, len);
  endtask

  // Reset lands between clock edges; outputs must already be cleared 1ns later.
  task automatic do_reset();
    @(negedge clk);
    compare_all("pre_rst");
    rst           = 1'b1;
    bus.enable    = 1'b0;
    bus.din_valid = 1'b0;
    #1;
    model_reset();
    compare_all("arst");
    @(negedge clk);
    compare_all("in_rst");
    rst = 1'b0;
    model_cycle(1'b0, 1'b0, bus.din, bus.acc_len);
  endtask

  initial begin
    bus.enable    = 1'b0;
    bus.din_valid = 1'b0;
    bus.din       = '0;
    bus.acc_len   = 16'd4;
    model_reset();
    @(negedge clk);
    compare_all("reset");
    rst = 1'b0;
    model_cycle(1'b0, 1'b0, 16'd0, 16'd4);

    // Continuous stream, with enable rising alongside a valid word that must be dropped.
    step(1'b1, 1'b1, 16'd99, 16'd4);
    for (int i = 1; i <= 12; i++) step(1'b1, 1'b1, 16'(i), 16'd4);
    step(1'b1, 1'b0, 16'd0, 16'd4);
    step(1'b1, 1'b0, 16'd0, 16'd4);

    // Gapped input, restarted from reset.
    do_reset();
    step(1'b1, 1'b0, 16'd0, 16'd3);
    for (int i = 1; i <= 9; i++) begin
      step(1'b1, 1'b1, 16'(i), 16'd3);
      step(1'b1, 1'b0, 16'(100 + i), 16'd3);
    end

    // Length change mid-frame.
    step(1'b0, 1'b0, 16'd0, 16'd4);
    step(1'b1, 1'b0, 16'd0, 16'd4);
    for (int i = 1; i <= 10; i++) step(1'b1, 1'b1, 16'(i), (i <= 2) ? 16'd4 : 16'd2);
    step(1'b1, 1'b0, 16'd0, 16'd2);

    // Degenerate lengths.
    for (int i = 1; i <= 5; i++) step(1'b1, 1'b1, 16'(200 + i), 16'd0);
    for (int i = 1; i <= 5; i++) step(1'b1, 1'b1, 16'(300 + i), 16'd1);
    step(1'b1, 1'b0, 16'd0, 16'd1);

    // Disable for three cycles with valid data present, then re-enable.
    step(1'b0, 1'b0, 16'd0, 16'd4);
    step(1'b1, 1'b0, 16'd0, 16'd4);
    for (int i = 1; i <= 6; i++) step(1'b1, 1'b1, 16'(i), 16'd4);
    for (int i = 7; i <= 9; i++) step(1'b0, 1'b1, 16'(i), 16'd4);
    step(1'b1, 1'b1, 16'd10, 16'd4);
    for (int i = 11; i <= 16; i++) step(1'b1, 1'b1, 16'(i), 16'd4);
    step(1'b1, 1'b0, 16'd0, 16'd4);

    // Async reset mid-frame, then restart.
    for (int i = 1; i <= 3; i++) step(1'b1, 1'b1, 16'(40 + i), 16'd4);
    do_reset();
    step(1'b1, 1'b0, 16'd0, 16'd4);
    for (int i = 1; i <= 6; i++) step(1'b1, 1'b1, 16'(50 + i), 16'd4);

    // Random traffic: occasional disables, resets and length changes.
    begin
      logic [15:0] len;
      len = 16'd3;
      for (int c = 0; c < 4000; c++) begin
        if ($urandom_range(0, 599) == 0) begin
          do_reset();
        end else begin
          if ($urandom_range(0, 19) == 0) len = 16'($urandom_range(0, 6));
          step($urandom_range(0, 59) != 0, $urandom_range(0, 9) < 7, 16'($urandom), len);
        end
      end
    end
    step(1'b0, 1'b0, 16'd0, 16'd1);
    step(1'b0, 1'b0, 16'd0, 16'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
